aq_djpeg_idct_outbuf: RTL

//  Receiving end of the IDCT output beat interface (Enable/Page/Count/Data0/Data1). Collects one
//  8x8 block of 9-bit signed samples into a ping-pong buffer, then streams it out in raster order
//  as level-shifted, clamped 8-bit pixels. Sits between the IDCT and the colour converter.

---
 rtl/aq_djpeg_pkg.sv | 20 ++
 rtl/aq_djpeg_outbuf_ram.sv | 35 +++
 rtl/aq_djpeg_idct_outbuf.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/aq_djpeg_pkg.sv
// rtl/aq_djpeg_pkg.sv - shared constants, read FSM states and pixel clamp for the IDCT output buffer
package aq_djpeg_pkg;

  localparam int BLK_SAMPLES   = 64;
  localparam int BEATS_PER_BLK = 32;
  localparam int PIX_W         = 8;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } rd_state_e;

  // Saturate a level-shifted sample into the 0..255 pixel range.
  function automatic logic [PIX_W-1:0] clamp_pixel(input logic signed [15:0] s);
    if (s < 16'sd0) return '0;
    else if (s > 16'sd255) return '1;
    else return s[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/aq_djpeg_outbuf_ram.sv
// rtl/aq_djpeg_outbuf_ram.sv - two-bank 64-entry sample store, dual write port, registered read
module aq_djpeg_outbuf_ram
  import aq_djpeg_pkg::*;
#(
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [5:0]        wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [5:0]        wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [5:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:2*BLK_SAMPLES-1];

  // Both samples of a beat land in the same bank; their addresses never collide.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_addr0}] <= wr_data0;
      mem[{wr_bank, wr_addr1}] <= wr_data1;
    end
  end

  // Registered read that holds its value while not enabled, so a stalled pixel stays put.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: rtl/aq_djpeg_idct_outbuf.sv
// rtl/aq_djpeg_idct_outbuf.sv - IDCT beat collector with ping-pong banks and raster pixel streamer
module aq_djpeg_idct_outbuf
  import aq_djpeg_pkg::*;
#(
  parameter int DATA_W      = 9,
  parameter int LEVEL_SHIFT = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ProcessInit,
  input  logic              DataInEnable,
  input  logic [2:0]        DataInPage,
  input  logic [1:0]        DataInCount,
  input  logic [DATA_W-1:0] Data0In,
  input  logic [DATA_W-1:0] Data1In,
  output logic              DataInIdle,
  output logic              DataOutValid,
  input  logic              DataOutReady,
  output logic [5:0]        DataOutIndex,
  output logic              DataOutLast,
  output logic [PIX_W-1:0]  DataOut,
  output logic              Overflow
);

  localparam logic [4:0] LAST_BEAT = 5'(BEATS_PER_BLK - 1);
  localparam logic [5:0] LAST_IDX  = 6'(BLK_SAMPLES - 1);

  logic                     clr;
  logic [1:0]               full;
  logic [1:0]               full_next;
  logic                     wr_bank;
  logic                     rd_bank;
  logic [4:0]               beat_cnt;
  logic                     overflow_q;
  rd_state_e                state;
  logic [5:0]               idx;
  logic                     valid_q;
  logic                     last_q;
  logic                     beat_ok;
  logic                     fill;
  logic                     accept;
  logic                     free;
  logic                     rd_en;
  logic                     rd_sel;
  logic [5:0]               rd_addr;
  logic [DATA_W-1:0]        rd_data;
  logic signed [DATA_W:0]   shifted;

  assign clr     = !rst || ProcessInit;
  assign beat_ok = DataInEnable && !full[wr_bank];
  assign fill    = beat_ok && (beat_cnt == LAST_BEAT);
  assign accept  = valid_q && DataOutReady;
  assign free    = accept && (idx == LAST_IDX);

  // Bank occupancy: a free and a fill in the same cycle always target different banks.
  always_comb begin
    full_next = full;
    if (free) full_next[rd_bank] = 1'b0;
    if (fill) full_next[wr_bank] = 1'b1;
  end

  // Read request: fetch index 0 on block start, the next index on accept, or the other bank's first pixel.
  always_comb begin
    rd_en   = 1'b0;
    rd_sel  = rd_bank;
    rd_addr = '0;
    if (state == ST_IDLE) begin
      rd_en = full[rd_bank];
    end else if (accept) begin
      if (idx != LAST_IDX) begin
        rd_en   = 1'b1;
        rd_addr = idx + 6'd1;
      end else if (full[!rd_bank]) begin
        rd_en  = 1'b1;
        rd_sel = !rd_bank;
      end
    end
  end

  // Write side: beat counting, bank switching and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (clr) begin
      full       <= '0;
      wr_bank    <= 1'b0;
      beat_cnt   <= '0;
      overflow_q <= 1'b0;
    end else begin
      full <= full_next;
      if (DataInEnable && full[wr_bank]) overflow_q <= 1'b1;
      if (beat_ok) begin
        beat_cnt <= beat_cnt + 5'd1;
        if (fill) wr_bank <= !wr_bank;
      end
    end
  end

  // Read FSM: stream a full bank in raster order, chaining straight into the other bank when it is ready.
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= ST_IDLE;
      rd_bank <= 1'b0;
      idx     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (full[rd_bank]) begin
            state   <= ST_STREAM;
            valid_q <= 1'b1;
            idx     <= '0;
            last_q  <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (accept) begin
            if (idx != LAST_IDX) begin
              idx    <= idx + 6'd1;
              last_q <= (idx == LAST_IDX - 6'd1);
            end else begin
              rd_bank <= !rd_bank;
              idx     <= '0;
              last_q  <= 1'b0;
              if (!full[!rd_bank]) begin
                state   <= ST_IDLE;
                valid_q <= 1'b0;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  aq_djpeg_outbuf_ram #(
    .DATA_W (DATA_W)
  ) u_ram (
    .clk      (clk),
    .wr_en    (beat_ok),
    .wr_bank  (wr_bank),
    .wr_addr0 ({DataInPage, 1'b0, DataInCount}),
    .wr_data0 (Data0In),
    .wr_addr1 ({DataInPage, 1'b1, ~DataInCount}),
    .wr_data1 (Data1In),
    .rd_en    (rd_en),
    .rd_bank  (rd_sel),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  assign shifted = $signed({rd_data[DATA_W-1], rd_data}) + $signed((DATA_W+1)'(LEVEL_SHIFT));

  assign DataInIdle   = !full[wr_bank];
  assign DataOutValid = valid_q;
  assign DataOutIndex = idx;
  assign DataOutLast  = last_q;
  assign DataOut      = valid_q ? clamp_pixel({{(15-DATA_W){shifted[DATA_W]}}, shifted}) : '0;
  assign Overflow     = overflow_q;

endmodule
